// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes; one operation in flight, result held until consumed.
// Optional iterative shift-add multiply for ALUControl 011 when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_result,
  output logic             Zero,
  output logic             Overflow
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

`ifdef SEQ_ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_EXEC = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t           state, state_n;
  logic             in_ready_n, out_valid_n, zero_n, ovf_n;
  logic [WIDTH-1:0] result_n;
  logic [WIDTH-1:0] sum, diff;
  logic             slt;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mcand_n, mplier, mplier_n, acc, acc_n, prod_step;
  logic [SHW-1:0]   cnt, cnt_n;
`endif

  assign sum  = A + B;
  assign diff = A - B;
  assign slt  = $signed(A) < $signed(B);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n     = state;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    result_n    = ALU_result;
    zero_n      = Zero;
    ovf_n       = Overflow;
`ifdef SEQ_ALU_MUL_EN
    mcand_n     = mcand;
    mplier_n    = mplier;
    acc_n       = acc;
    cnt_n       = cnt;
    prod_step   = acc + (mplier[0] ? mcand : '0);
`endif
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_n     = S_DONE;
          in_ready_n  = 1'b0;
          out_valid_n = 1'b1;
          zero_n      = (diff == '0);
          ovf_n       = 1'b0;
          case (ALUControl)
            OP_ADD: begin
              result_n = sum;
              ovf_n    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
              result_n = diff;
              ovf_n    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: result_n = A & B;
            OP_OR:  result_n = A | B;
            OP_SLT: result_n = WIDTH'(slt);
            OP_SLL: result_n = A << B[SHW-1:0];
            OP_SRL: result_n = A >> B[SHW-1:0];
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
              state_n     = S_EXEC;
              out_valid_n = 1'b0;
              result_n    = ALU_result;
              mcand_n     = A;
              mplier_n    = B;
              acc_n       = '0;
              cnt_n       = '0;
            end
`endif
            default: result_n = '0;
          endcase
        end
      end
`ifdef SEQ_ALU_MUL_EN
      // One partial product per cycle; the last step writes the result directly.
      S_EXEC: begin
        acc_n    = prod_step;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt + SHW'(1);
        if (cnt == SHW'(WIDTH - 1)) begin
          state_n     = S_DONE;
          out_valid_n = 1'b1;
          result_n    = prod_step;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          state_n     = S_IDLE;
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
        end
      end
      default: begin
        state_n     = S_IDLE;
        out_valid_n = 1'b0;
        in_ready_n  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      ALU_result <= '0;
      Zero       <= 1'b0;
      Overflow   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
`endif
    end else begin
      state      <= state_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      ALU_result <= result_n;
      Zero       <= zero_n;
      Overflow   <= ovf_n;
`ifdef SEQ_ALU_MUL_EN
      mcand      <= mcand_n;
      mplier     <= mplier_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=8): transaction-level model plus directed literal checks.
module tb_seq_alu;

  localparam int W   = 8;
  localparam int MOD = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   ALUControl = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ALU_result;
  logic         Zero;
  logic         Overflow;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_result(ALU_result), .Zero(Zero), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for one operation on unsigned 8-bit operand values.
  function automatic void alu_model(input int op, input int a, input int b,
                                    output int r, output bit z, output bit o);
    int sa, sb, s;
    sa = (a >= MOD/2) ? a - MOD : a;
    sb = (b >= MOD/2) ? b - MOD : b;
    z = (a == b);
    o = 1'b0;
    r = 0;
    case (op)
      2: begin s = sa + sb; r = (a + b) % MOD; o = (s > 127) || (s < -128); end
      6: begin s = sa - sb; r = (a - b + MOD) % MOD; o = (s > 127) || (s < -128); end
      0: r = a & b;
      1: r = a | b;
      7: r = (sa < sb) ? 1 : 0;
      4: r = (a << (b % W)) % MOD;
      5: r = a >> (b % W);
`ifdef SEQ_ALU_MUL_EN
      3: r = (a * b) % MOD;
`endif
      default: r = 0;
    endcase
  endfunction

  // Transaction-level model: idle/busy/holding, with a latency countdown for MUL.
  bit m_ready = 1'b1, m_valid = 1'b0, m_known = 1'b1, m_z = 1'b0, m_o = 1'b0;
  bit p_z, p_o;
  int m_res = 0, p_res = 0, m_wait = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_ready = 1'b1; m_valid = 1'b0; m_known = 1'b1;
      m_res = 0; m_z = 1'b0; m_o = 1'b0; m_wait = 0;
    end else if (m_ready && in_valid) begin
      alu_model(int'(ALUControl), int'(A), int'(B), p_res, p_z, p_o);
      m_ready = 1'b0;
`ifdef SEQ_ALU_MUL_EN
      if (ALUControl == 3'b011) begin
        m_wait = W; m_known = 1'b0;
      end else begin
        m_valid = 1'b1; m_known = 1'b1; m_res = p_res; m_z = p_z; m_o = p_o;
      end
`else
      m_valid = 1'b1; m_known = 1'b1; m_res = p_res; m_z = p_z; m_o = p_o;
`endif
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1; m_known = 1'b1; m_res = p_res; m_z = p_z; m_o = p_o;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0; m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("in_ready", int'(in_ready), int'(m_ready));
      check("out_valid", int'(out_valid), int'(m_valid));
      if (m_known) begin
        check("ALU_result", int'(ALU_result), m_res);
        check("Zero", int'(Zero), int'(m_z));
        check("Overflow", int'(Overflow), int'(m_o));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    check("wait_in_ready", int'(in_ready), 1);
    ALUControl = op; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int exp_lat, input int exp_res,
                        input int exp_z, input int exp_o);
    int lat;
    issue(op, a, b);
    wait_valid(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_result"}, int'(ALU_result), exp_res);
    check({name, "_zero"}, int'(Zero), exp_z);
    check({name, "_ovf"}, int'(Overflow), exp_o);
    consume();
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    run = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(ALU_result), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run_op("add_ovf", 3'b010, 8'h7F, 8'h01, 1, 8'h80, 0, 1);
    run_op("sub_eq", 3'b110, 8'h05, 8'h05, 1, 8'h00, 1, 0);
    run_op("slt_neg", 3'b111, 8'hFF, 8'h01, 1, 8'h01, 0, 0);
    run_op("sll", 3'b100, 8'h81, 8'h09, 1, 8'h02, 0, 0);
    run_op("srl", 3'b101, 8'h80, 8'h03, 1, 8'h10, 0, 0);
    run_op("and", 3'b000, 8'hF0, 8'h3C, 1, 8'h30, 0, 0);
    run_op("or", 3'b001, 8'hF0, 8'h3C, 1, 8'hFC, 0, 0);
    run_op("sub_ovf", 3'b110, 8'h80, 8'h01, 1, 8'h7F, 0, 1);
    run_op("slt_eq", 3'b111, 8'h33, 8'h33, 1, 8'h00, 1, 0);

    // Stall with a competing request that must be ignored.
    begin
      int lat;
      issue(3'b010, 8'h03, 8'h04);
      wait_valid(lat);
      ALUControl = 3'b001; A = 8'hAA; B = 8'h55; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("stall_valid", int'(out_valid), 1);
        check("stall_result", int'(ALU_result), 8'h07);
        check("stall_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      consume();
    end

`ifdef SEQ_ALU_MUL_EN
    run_op("mul", 3'b011, 8'd13, 8'd11, 9, 8'h8F, 0, 0);
    run_op("mul_wrap", 3'b011, 8'hFF, 8'hFF, 9, 8'h01, 1, 0);
    issue(3'b011, 8'd13, 8'd11);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_result", int'(ALU_result), 0);
    repeat (12) @(negedge clk);
    check("mid_rst_quiet", int'(out_valid), 0);
`else
    run_op("mul_undef", 3'b011, 8'd13, 8'd11, 1, 8'h00, 0, 0);
`endif
    run_op("add_after", 3'b010, 8'h10, 8'h20, 1, 8'h30, 0, 0);
    repeat (3) @(negedge clk);
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
